// File: rtl/copy_token_splitter.sv
// Pops Snappy copy tokens and splits each into overlap-safe history-buffer copy commands.
// Optional build macro COPY_SPLIT_ALIGN_EN keeps every command inside one MAX_CHUNK-aligned destination line.
module copy_token_splitter #(
  parameter int unsigned MAX_CHUNK = 8,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic [32:0]       fifo_dout,
  output logic              fifo_rd_en,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_src,
  output logic [ADDR_W-1:0] cmd_dst,
  output logic [3:0]        cmd_len,
  output logic              cmd_last,
  input  logic              lit_adv,
  input  logic [3:0]        lit_bytes,
  output logic              busy,
  output logic              err_offset0
);

  typedef enum logic [1:0] {IDLE, FETCH, SPLIT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic [6:0]        rem_len;
  logic [6:0]        rem_after;
  logic [ADDR_W-1:0] off;
  logic              lastflag;

  logic              hs;
  logic              done;
  logic [ADDR_W-1:0] lit_inc;
  int unsigned       room;
  logic [6:0]        fetch_len;
  logic [ADDR_W-1:0] fetch_off;
  logic [3:0]        fetch_chunk;
  logic [3:0]        next_chunk;
  logic [9:0]        unused_reserved;

  assign unused_reserved = fifo_dout[9:0];

  // Never exceed the offset so a chunk only reads bytes already written.
  function automatic logic [3:0] calc_chunk(input logic [6:0] rem,
                                            input logic [ADDR_W-1:0] offv,
                                            input int unsigned lim);
    int unsigned c;
    c = MAX_CHUNK;
    if (lim < c) c = lim;
    if (32'(rem) < c) c = 32'(rem);
    if (32'(offv) < c) c = 32'(offv);
    return 4'(c);
  endfunction

  always_comb begin
    hs        = cmd_valid & cmd_ready;
    rem_after = rem_len - 7'(cmd_len);
    done      = hs && (rem_after == '0);
    lit_inc   = lit_adv ? ADDR_W'(lit_bytes) : '0;

    if (done && lastflag)
      wr_addr_nxt = '0;
    else
      wr_addr_nxt = wr_addr + (hs ? ADDR_W'(cmd_len) : '0) + lit_inc;

`ifdef COPY_SPLIT_ALIGN_EN
    room = MAX_CHUNK - (32'(wr_addr_nxt) % MAX_CHUNK);
`else
    room = MAX_CHUNK;
`endif

    fetch_len   = 7'(fifo_dout[31:26]) + 7'd1;
    fetch_off   = ADDR_W'(fifo_dout[25:10]);
    fetch_chunk = calc_chunk(fetch_len, fetch_off, room);
    next_chunk  = calc_chunk(rem_after, off, room);

    fifo_rd_en = rst_n & ~fifo_empty &
                 ((state == IDLE) | ((state == SPLIT) & done));
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_addr     <= '0;
      rem_len     <= '0;
      off         <= '0;
      lastflag    <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_src     <= '0;
      cmd_dst     <= '0;
      cmd_len     <= '0;
      cmd_last    <= 1'b0;
      err_offset0 <= 1'b0;
    end else begin
      wr_addr <= wr_addr_nxt;
      case (state)
        IDLE: begin
          if (fifo_rd_en) state <= FETCH;
        end
        FETCH: begin
          rem_len  <= fetch_len;
          off      <= fetch_off;
          lastflag <= fifo_dout[32];
          if (fetch_off == '0) begin
            err_offset0 <= 1'b1;
            state       <= IDLE;
          end else begin
            state     <= SPLIT;
            cmd_valid <= 1'b1;
            cmd_dst   <= wr_addr_nxt;
            cmd_src   <= wr_addr_nxt - fetch_off;
            cmd_len   <= fetch_chunk;
            cmd_last  <= fifo_dout[32] & (fetch_len == 7'(fetch_chunk));
          end
        end
        SPLIT: begin
          if (hs) begin
            rem_len <= rem_after;
            if (rem_after == '0) begin
              cmd_valid <= 1'b0;
              cmd_src   <= '0;
              cmd_dst   <= '0;
              cmd_len   <= '0;
              cmd_last  <= 1'b0;
              state     <= fifo_rd_en ? FETCH : IDLE;
            end else begin
              // Next command is precomputed so fields stay registered and stable under stall.
              cmd_dst  <= wr_addr_nxt;
              cmd_src  <= wr_addr_nxt - off;
              cmd_len  <= next_chunk;
              cmd_last <= lastflag & (rem_after == 7'(next_chunk));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/copy_token_splitter.md
# copy_token_splitter

Downstream consumer of the 33-bit parser copy-token FIFO in the Snappy decompressor. It pops one copy token at a time and tracks the running 16-bit output write address. Each copy is split into a sequence of history-buffer copy commands of at most 8 bytes. No command reads bytes that are not yet written: self-overlapping copies, where offset < length, are chunked by offset. Commands go to the history-buffer copy engine over a valid/ready handshake.

## Interface
Parameters
- MAX_CHUNK, 8: maximum bytes per command; power of two, 1..8.
- ADDR_W, 16: width of the history write address and offset; address arithmetic wraps modulo 2^ADDR_W.

Ports
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fifo_empty  in  1  token FIFO empty.
- fifo_dout  in  33  token, valid the cycle after fifo_rd_en. Fields: [32] last (end of block), [31:26] len_m1 (length = len_m1+1, 1..64), [25:10] offset, [9:0] reserved (ignored).
- fifo_rd_en  out  1  pop request; never asserted while fifo_empty=1.
- cmd_valid  out  1  command valid.
- cmd_ready  in  1  copy engine accepts command.
- cmd_src  out  ADDR_W  source address = dst − offset (mod 2^ADDR_W).
- cmd_dst  out  ADDR_W  destination address.
- cmd_len  out  4  bytes in this command, 1..MAX_CHUNK.
- cmd_last  out  1  final chunk of a token whose last flag is set.
- lit_adv  in  1  literal path wrote bytes this cycle.
- lit_bytes  in  4  byte count for lit_adv (0..8).
- busy  out  1  state ≠ IDLE.
- err_offset0  out  1  sticky; set when a token with offset=0 is popped.

## Operation
- States: IDLE, FETCH, SPLIT.
- IDLE: if !fifo_empty, assert fifo_rd_en (combinational) and go to FETCH.
- FETCH: latch fifo_dout into rem_len (7 bits, = len_m1+1), off, lastflag.
  - If offset = 0: set err_offset0, discard the token and go to IDLE.
  - Otherwise go to SPLIT.
- SPLIT: cmd_valid=1. chunk = min(rem_len, MAX_CHUNK, off). cmd_len=chunk, cmd_dst=wr_addr, cmd_src=wr_addr−off.
  - cmd_last = lastflag & (rem_len==chunk).
  - On cmd_valid & cmd_ready: wr_addr += chunk, rem_len −= chunk.
  - If rem_len becomes 0: when !fifo_empty, assert fifo_rd_en in the same cycle and go to FETCH; otherwise go to IDLE.
- wr_addr is a 16-bit register that wraps from 0xFFFF to 0x0000.
  - lit_adv adds lit_bytes in any state.
  - If lit_adv coincides with a command handshake, wr_addr += chunk + lit_bytes.
  - A literal arriving during a token is an upstream protocol violation. The bench must not drive it.
- After lastflag's final chunk is accepted, wr_addr resets to 0 for the next block.
- Command fields are stable while cmd_valid=1 and cmd_ready=0.

## Timing
- Reset values: fifo_rd_en=0, cmd_valid=0, cmd_src=0, cmd_dst=0, cmd_len=0, cmd_last=0, busy=0, err_offset0=0. State resets to IDLE, wr_addr to 0, rem_len to 0.
- Pop at cycle t gives data at t+1 (FETCH) and cmd_valid at t+2.
- With cmd_ready held high, the block issues one chunk per cycle. Each new token costs one FETCH bubble.
- Reset mid-token drops the remaining chunks. No command is emitted after rst_n falls.

## Configuration
- COPY_SPLIT_ALIGN_EN defined:
  - chunk is additionally limited to MAX_CHUNK − (wr_addr mod MAX_CHUNK).
  - No command crosses a MAX_CHUNK-aligned destination line.
- Undefined: the alignment term is absent. Chunks depend only on rem_len, MAX_CHUNK and off.

## Test plan
- Reset, empty FIFO: all outputs 0, fifo_rd_en never asserted over 20 cycles.
- Token len=20, off=100, wr_addr=0, cmd_ready=1, no ALIGN:
  - Required: commands (dst 0, src 0xFF9C, len 8), (8, 0xFFA4, 8), (16, 0xFFAC, 4) on consecutive cycles.
  - Required: first command 2 cycles after the pop; wr_addr ends at 20.
- Token len=10, off=3, lastflag=1:
  - Required: lengths 3,3,3,1, each src = dst−3.
  - Required: cmd_last only on the 4th command; wr_addr is 0 afterwards.
- Token len=9, off=64, cmd_ready toggled 0/1 every cycle: fields are held while stalled, exactly 2 commands are emitted (8, then 1), and there are no duplicates.
- Token offset=0: err_offset0 rises the cycle after the pop and no command is emitted. The next token (len=4, off=4) gives one command of len 4.
- ALIGN_EN, wr_addr=0xFFFD, token len=8, off=32:
  - Required: commands (dst 0xFFFD, len 3) then (dst 0x0000, len 5); wr_addr ends at 0x0005.
  - Without ALIGN_EN: a single command of len 8.
